bldc_pwm_commutator: RTL and testbench
======================================

# bldc_pwm_commutator

Generates the per-switch gate commands for a three-phase BLDC bridge from the Hall sensor code, a duty value and a direction bit. It contains the edge-aligned PWM carrier, shadowed duty/period registers, the Hall synchronizer/filter and the six-step commutation table. It sits directly upstream of the dead-time insertion stage, which receives the six raw switch commands and turns them into dead-time-separated gate signals.

## Interface
Parameters:
- CNT_W, 8, carrier counter, DUTY and PERIOD width
- FILT_N, 2, consecutive identical synchronized Hall samples needed to accept a new code (range 1..4)

Ports:
- CLK  in  1  system clock
- RSTn  in  1  reset, asynchronous, active-low
- EN  in  1  run enable; low forces all switches off
- DIR  in  1  0 = forward, 1 = reverse
- DUTY  in  CNT_W  PWM compare value (high-side on-time in counts)
- PERIOD  in  CNT_W  carrier top; carrier period = PERIOD+1 cycles
- HALL  in  3  raw asynchronous Hall code {Ha,Hb,Hc}
- HS  out  3  high-side commands {A,B,C}, to dead-time stage
- LS  out  3  low-side commands {A,B,C}, to dead-time stage
- SYNC  out  1  one-cycle pulse on carrier wrap
- HALL_ERR  out  1  sticky invalid-Hall-code flag

## Operation
- Carrier: cnt counts 0..per_sh, then wraps to 0. SYNC = 1 in the cycle cnt == per_sh.
- Shadows: duty_sh/per_sh load from DUTY/PERIOD in the wrap cycle, and every cycle while EN = 0. Mid-period input changes have no effect.
- pwm_on = (cnt < duty_sh), unsigned. duty_sh = 0 gives 0%. duty_sh > per_sh gives 100%.
- per_sh = 0: cnt stays 0, SYNC is held high, and pwm_on = (duty_sh != 0).
- Hall path: 2-flop synchronizer, then filter. hall_q takes the synchronized value once it has been identical for FILT_N consecutive cycles.
- Codes 000 and 111 are invalid. When either is accepted, HALL_ERR sets, all HS/LS go to 0, and both stay so until EN = 0.
- Commutation for DIR = 0 (source phase+, sink phase−):
  - 101: A+ B−
  - 100: A+ C−
  - 110: B+ C−
  - 010: B+ A−
  - 011: C+ A−
  - 001: C+ B−
- DIR = 1: same Hall code with source and sink swapped (for example 101: B+ A−).
- Outputs:
  - HS[source] = pwm_on.
  - LS[sink] = 1 for the whole sector (high-side chopping only).
  - All other bits are 0.
  - A phase never has HS and LS high together.
- EN = 0: cnt held at 0, outputs 0, HALL_ERR cleared.
- DIR changes take effect on the next cycle. Safe switching is left to the dead-time stage.

## Timing
- Reset: all outputs 0, cnt = 0, duty_sh = per_sh = 0, the synchronizer and filter hold 000 with error suppressed, HALL_ERR = 0.
- HS/LS/SYNC/HALL_ERR are registered.
- HALL change to HS/LS change takes 2 (sync) + FILT_N (filter) + 1 (output reg) cycles, i.e. 5 cycles at FILT_N = 2. The change happens mid-period and is not aligned to the carrier.
- Duty/period change to effect: the first carrier period after the next wrap.
- EN falling edge: outputs 0 on the next CLK edge.
- EN rising edge: cnt = 0 and PWM starts with the freshly loaded shadows. The first HS pulse appears one cycle after EN is sampled high.
- Hall code changing during the filter window: the filter count restarts, and a glitch shorter than FILT_N cycles is ignored.
- Reset asserted mid-operation: all outputs go to 0 asynchronously.
- Reset release: the first valid Hall code must pass the full filter before any switch turns on.

## Structure
- Package bldc_pkg holds:
  - Hall code constants and the invalid-code check function
  - the phase index constants A/B/C
  - the 6-entry commutation table as a constant array of {source, sink}
- Sub-module hall_sync_filter contains the synchronizer and the FILT_N filter. It outputs the accepted code and a 1-cycle "new code" strobe.
- The carrier, shadows, table lookup and output registers stay in the top module.

## Test plan
- PERIOD = 9, DUTY = 3, HALL = 101, DIR = 0, EN = 1 → HS = 100 for 3 of every 10 cycles, LS = 010 constant, SYNC every 10th cycle.
- Step HALL through 101, 100, 110, 010, 011, 001 → each sector's HS/LS pair appears exactly 5 cycles after the change. For DIR = 1, 101 gives HS = 010 chopping and LS = 100.
- Change DUTY 3 → 7 mid-period → the current period keeps 3 on-cycles and the next period has 7. DUTY = 0 gives HS = 000, DUTY = 10 gives HS constant high.
- 1-cycle HALL glitch 101 → 100 → 101 → no output change. HALL = 111 held for 3 cycles → HALL_ERR = 1 and HS = LS = 000, latched until EN toggles low.
- Assert RSTn low mid-pulse → outputs 0 immediately. After release with HALL = 100 → LS = 001 and chopping starts on HS = 100 only after the filter latency.
- Randomized DUTY/PERIOD/HALL/DIR sequences → assertions hold that HS & LS == 0 and that at most one HS and one LS bit is high at any time.

Source files
------------

// File: rtl/bldc_pkg.sv
// Shared constants for the BLDC commutator: Hall codes, phase indices and
// the six-step commutation table.
// Phase indices map directly onto bit positions of the {A,B,C} command buses.
package bldc_pkg;

  localparam logic [2:0] HALL_000 = 3'b000;
  localparam logic [2:0] HALL_001 = 3'b001;
  localparam logic [2:0] HALL_010 = 3'b010;
  localparam logic [2:0] HALL_011 = 3'b011;
  localparam logic [2:0] HALL_100 = 3'b100;
  localparam logic [2:0] HALL_101 = 3'b101;
  localparam logic [2:0] HALL_110 = 3'b110;
  localparam logic [2:0] HALL_111 = 3'b111;

  // A is the MSB of {A,B,C}, so the index doubles as the bit position
  typedef logic [1:0] phase_t;
  localparam phase_t PH_A = 2'd2;
  localparam phase_t PH_B = 2'd1;
  localparam phase_t PH_C = 2'd0;

  typedef struct packed {
    phase_t src;
    phase_t snk;
  } comm_t;

  // Forward-direction {source, sink}, ordered by sector 0..5
  // (Hall 101, 100, 110, 010, 011, 001)
  localparam comm_t COMM_TBL [6] = '{
    '{src: PH_A, snk: PH_B},
    '{src: PH_A, snk: PH_C},
    '{src: PH_B, snk: PH_C},
    '{src: PH_B, snk: PH_A},
    '{src: PH_C, snk: PH_A},
    '{src: PH_C, snk: PH_B}
  };

  function automatic logic hall_invalid(input logic [2:0] code);
    return (code == HALL_000) || (code == HALL_111);
  endfunction

  // Invalid codes map to sector 0; callers gate on hall_invalid separately
  function automatic logic [2:0] hall_sector(input logic [2:0] code);
    case (code)
      HALL_101: return 3'd0;
      HALL_100: return 3'd1;
      HALL_110: return 3'd2;
      HALL_010: return 3'd3;
      HALL_011: return 3'd4;
      HALL_001: return 3'd5;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/bldc_pwm_commutator_hall_sync_filter.sv
// Hall input synchronizer plus FILT_N-sample agreement filter.
// Latency: 2 sync cycles + FILT_N filter cycles from raw change to code.
// No backpressure: new_code is a single-cycle strobe on every accepted change.
module hall_sync_filter #(
  parameter int FILT_N = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] hall_raw,
  output logic [2:0] code,
  output logic       new_code
);

  localparam logic [2:0] FILT_L = 3'(FILT_N);

  logic [2:0] sync1, sync2, cand;
  logic [2:0] run, run_nxt;
  logic       accept;

  // Two-flop synchronizer for the asynchronous Hall lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= hall_raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive identical samples; any difference restarts the run at 1
  always_comb begin
    run_nxt = 3'd1;
    if (sync2 == cand) begin
      run_nxt = (run == 3'd4) ? run : run + 3'd1;
    end
    accept = (run_nxt >= FILT_L) && (sync2 != code);
  end

  // Filter state and accepted-code register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand     <= 3'b000;
      run      <= 3'd0;
      code     <= 3'b000;
      new_code <= 1'b0;
    end else begin
      cand     <= sync2;
      run      <= run_nxt;
      new_code <= accept;
      if (accept) begin
        code <= sync2;
      end
    end
  end

endmodule

// File: rtl/bldc_pwm_commutator.sv
// Six-step BLDC commutator with edge-aligned PWM carrier and shadowed duty/period.
// Latency: registered outputs, Hall-to-switch 3+FILT_N cycles, EN-to-off 1 cycle.
// No backpressure: free-running, feeds the dead-time stage every cycle.
module bldc_pwm_commutator
  import bldc_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int FILT_N = 2
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             EN,
  input  logic             DIR,
  input  logic [CNT_W-1:0] DUTY,
  input  logic [CNT_W-1:0] PERIOD,
  input  logic [2:0]       HALL,
  output logic [2:0]       HS,
  output logic [2:0]       LS,
  output logic             SYNC,
  output logic             HALL_ERR
);

  logic [CNT_W-1:0] cnt, duty_sh, per_sh;
  logic [2:0]       hall_q;
  logic             new_code;
  logic             wrap, pwm_on, err_nxt;
  comm_t            ent;
  phase_t           src, snk;
  logic [2:0]       hs_nxt, ls_nxt;

  hall_sync_filter #(.FILT_N(FILT_N)) u_hall (
    .clk      (CLK),
    .rst_n    (RSTn),
    .hall_raw (HALL),
    .code     (hall_q),
    .new_code (new_code)
  );

  // per_sh == 0 makes every cycle a wrap, so cnt stays 0 and SYNC stays high;
  // cnt < duty_sh then reduces to duty_sh != 0
  assign wrap   = (cnt == per_sh);
  assign pwm_on = (cnt < duty_sh);

  // Carrier counter; shadows reload only at wrap or while disabled
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt     <= '0;
      duty_sh <= '0;
      per_sh  <= '0;
    end else if (!EN || wrap) begin
      cnt     <= '0;
      duty_sh <= DUTY;
      per_sh  <= PERIOD;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Table lookup: reverse swaps source and sink; invalid code or latched error blanks all
  always_comb begin
    hs_nxt  = 3'b000;
    ls_nxt  = 3'b000;
    ent     = COMM_TBL[hall_sector(hall_q)];
    src     = DIR ? ent.snk : ent.src;
    snk     = DIR ? ent.src : ent.snk;
    err_nxt = EN && (HALL_ERR || (new_code && hall_invalid(hall_q)));
    if (EN && !err_nxt && !hall_invalid(hall_q)) begin
      hs_nxt[src] = pwm_on;
      ls_nxt[snk] = 1'b1;
    end
  end

  // Output registers toward the dead-time stage
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      HS       <= 3'b000;
      LS       <= 3'b000;
      SYNC     <= 1'b0;
      HALL_ERR <= 1'b0;
    end else begin
      HS       <= hs_nxt;
      LS       <= ls_nxt;
      SYNC     <= EN && wrap;
      HALL_ERR <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bldc_pwm_commutator.sv
// Directed bench for bldc_pwm_commutator: carrier/duty behaviour, commutation table,
// Hall filtering, error latching, async reset, plus a randomized safety sweep.
module tb_bldc_pwm_commutator;

  logic       CLK = 1'b0;
  logic       RSTn, EN, DIR;
  logic [7:0] DUTY, PERIOD;
  logic [2:0] HALL, HS, LS;
  logic       SYNC, HALL_ERR;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [2:0] hall;
    logic       dir;
    logic [2:0] hs;
    logic [2:0] ls;
  } vec_t;

  vec_t       vecs [12];
  logic [2:0] codes [6];
  logic [5:0] prev;
  logic [2:0] exp_hs;

  bldc_pwm_commutator #(.CNT_W(8), .FILT_N(2)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .EN       (EN),
    .DIR      (DIR),
    .DUTY     (DUTY),
    .PERIOD   (PERIOD),
    .HALL     (HALL),
    .HS       (HS),
    .LS       (LS),
    .SYNC     (SYNC),
    .HALL_ERR (HALL_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Drop EN for one edge so the shadows reload and cnt restarts; the next step is carrier cycle 0
  task automatic restart();
    EN = 1'b0;
    step();
    EN = 1'b1;
  endtask

  task automatic run_duty(input int d, input int per, input int ncyc,
                          input logic [2:0] hs_on, input logic [2:0] ls_on);
    logic [2:0] e;
    for (int i = 0; i < ncyc; i++) begin
      step();
      e = ((i % (per + 1)) < d) ? hs_on : 3'b000;
      chk("pwm_hs", HS, e);
      chk("pwm_ls", LS, ls_on);
      chk("pwm_sync", SYNC, (i % (per + 1)) == per);
    end
  endtask

  initial begin
    vecs[0]  = '{3'b100, 1'b0, 3'b100, 3'b001};
    vecs[1]  = '{3'b110, 1'b0, 3'b010, 3'b001};
    vecs[2]  = '{3'b010, 1'b0, 3'b010, 3'b100};
    vecs[3]  = '{3'b011, 1'b0, 3'b001, 3'b100};
    vecs[4]  = '{3'b001, 1'b0, 3'b001, 3'b010};
    vecs[5]  = '{3'b101, 1'b0, 3'b100, 3'b010};
    vecs[6]  = '{3'b100, 1'b1, 3'b001, 3'b100};
    vecs[7]  = '{3'b110, 1'b1, 3'b001, 3'b010};
    vecs[8]  = '{3'b010, 1'b1, 3'b100, 3'b010};
    vecs[9]  = '{3'b011, 1'b1, 3'b100, 3'b001};
    vecs[10] = '{3'b001, 1'b1, 3'b010, 3'b001};
    vecs[11] = '{3'b101, 1'b1, 3'b010, 3'b100};
    codes = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    // Reset state
    RSTn = 1'b0; EN = 1'b0; DIR = 1'b0;
    DUTY = 8'd3; PERIOD = 8'd9; HALL = 3'b101;
    repeat (3) step();
    chk("rst_hs", HS, 3'b000);
    chk("rst_ls", LS, 3'b000);
    chk("rst_sync", SYNC, 1'b0);
    chk("rst_err", HALL_ERR, 1'b0);

    // Disabled: Hall settles but nothing drives
    RSTn = 1'b1;
    repeat (6) step();
    chk("dis_out", {HS, LS, SYNC}, 7'd0);

    // Basic PWM: 3 of 10 on, LS constant, SYNC on cycle 9 of each period
    EN = 1'b1;
    run_duty(3, 9, 20, 3'b100, 3'b010);

    // Commutation table at 100% duty, 5-cycle Hall latency
    DUTY = 8'd200;
    restart();
    step();
    chk("full_on", {HS, LS}, {3'b100, 3'b010});
    prev = {HS, LS};
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        DIR = 1'b1;
        step();
        chk("dir_rev_101", {HS, LS}, {3'b010, 3'b100});
        prev = {3'b010, 3'b100};
      end
      HALL = vecs[i].hall;
      DIR  = vecs[i].dir;
      for (int k = 1; k <= 4; k++) begin
        step();
        chk("comm_hold", {HS, LS}, prev);
      end
      step();
      chk("comm_new", {HS, LS}, {vecs[i].hs, vecs[i].ls});
      prev = {vecs[i].hs, vecs[i].ls};
    end

    // Mid-period duty change: current period keeps 3, next gets 7
    DIR = 1'b0; DUTY = 8'd3;
    restart();
    for (int i = 0; i < 20; i++) begin
      step();
      exp_hs = (i < 10) ? ((i < 3) ? 3'b100 : 3'b000) : ((i - 10 < 7) ? 3'b100 : 3'b000);
      chk("duty_chg_hs", HS, exp_hs);
      if (i == 4) DUTY = 8'd7;
    end

    // Duty boundaries and zero period
    DUTY = 8'd0;  restart(); run_duty(0, 9, 10, 3'b100, 3'b010);
    DUTY = 8'd10; restart(); run_duty(10, 9, 10, 3'b100, 3'b010);
    PERIOD = 8'd0; DUTY = 8'd1; restart(); run_duty(1, 0, 4, 3'b100, 3'b010);
    DUTY = 8'd0;  restart(); run_duty(0, 0, 4, 3'b100, 3'b010);
    PERIOD = 8'd9; DUTY = 8'd10; restart(); run_duty(10, 9, 3, 3'b100, 3'b010);

    // One-cycle glitch is filtered out
    HALL = 3'b100;
    step();
    HALL = 3'b101;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("glitch_hold", {HS, LS}, {3'b100, 3'b010});
    end

    // Invalid code 111 for 3 cycles latches the error
    HALL = 3'b111;
    repeat (3) step();
    HALL = 3'b101;
    step();
    chk("err_pre", {HALL_ERR, HS, LS}, {1'b0, 3'b100, 3'b010});
    step();
    chk("err_set", {HALL_ERR, HS, LS}, {1'b1, 6'd0});
    for (int k = 0; k < 8; k++) begin
      step();
      chk("err_sticky", {HALL_ERR, HS, LS}, {1'b1, 6'd0});
    end
    EN = 1'b0;
    step();
    chk("err_clr", {HALL_ERR, HS, LS}, 7'd0);
    EN = 1'b1;
    step();
    chk("err_resume", {HALL_ERR, HS, LS}, {1'b0, 3'b100, 3'b010});

    // Async reset mid-pulse, then full filter latency before switching
    step();
    #2;
    RSTn = 1'b0;
    HALL = 3'b100;
    #1;
    chk("async_rst", {HS, LS}, 6'd0);
    step();
    step();
    RSTn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("post_rst_wait", {HS, LS}, 6'd0);
    end
    step();
    chk("post_rst_on", {HS, LS}, {3'b100, 3'b001});

    // Randomized sweep: no shoot-through, at most one HS and one LS bit
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) HALL = codes[$urandom_range(0, 5)];
      if ($urandom_range(0, 199) == 0) HALL = 3'b111;
      if ($urandom_range(0, 31) == 0) DIR = ~DIR;
      if ($urandom_range(0, 19) == 0) DUTY = 8'($urandom_range(0, 40));
      if ($urandom_range(0, 29) == 0) PERIOD = 8'($urandom_range(0, 30));
      if ($urandom_range(0, 99) == 0) EN = ~EN;
      step();
      chk("rand_no_overlap", HS & LS, 3'b000);
      chk("rand_one_hs", $countones(HS) <= 1, 1'b1);
      chk("rand_one_ls", $countones(LS) <= 1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
